// File: rtl/rr_cs_arbiter8_pkg.sv
// Shared constants and the rotating-priority search used by the 8-way
// chip-select arbiter.
package rr_cs_arbiter8_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_TURN  = 2'd2;

   localparam logic [7:0] CS_IDLE  = 8'hFF;

   // First set request bit at or above ptr, wrapping 7->0; returns 0 when req is empty.
   function automatic logic [2:0] rr_first(input logic [7:0] req, input logic [2:0] ptr);
      logic [2:0] idx;
      logic       found;
      idx   = 3'd0;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (!found && req[3'(ptr + 3'(i))]) begin
            idx   = 3'(ptr + 3'(i));
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_cs_arbiter8_decode.sv
// Combinational 3-to-8 active-low chip-select decoder with enable.
module cs_decode3_8
   import rr_cs_arbiter8_pkg::*;
(
   input  logic       en,
   input  logic [2:0] idx,
   output logic [7:0] cs_n
);

   always_comb begin
      cs_n = CS_IDLE;
      if (en) cs_n[idx] = 1'b0;
   end

endmodule

// File: rtl/rr_cs_arbiter8.sv
// Round-robin arbiter for one shared 8-way chip-select resource, with a
// hold limit under contention and a one-cycle turnaround between owners.
module rr_cs_arbiter8
   import rr_cs_arbiter8_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] req,
   output logic       gnt_valid,
   output logic [2:0] gnt_idx,
   output logic [7:0] cs_n,
   output logic       forced
);

   localparam int HCW = $clog2(MAX_HOLD + 1);
   localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);

   logic [1:0]     state, nxt_state;
   logic [2:0]     ptr, nxt_ptr;
   logic [HCW-1:0] hold_cnt, nxt_hold;
   logic [2:0]     nxt_idx, win;
   logic           nxt_valid, nxt_forced;
   logic [7:0]     others, nxt_cs_n;

   assign win    = rr_first(req, ptr);
   assign others = req & ~(8'h01 << gnt_idx);

   always_comb begin
      nxt_state  = state;
      nxt_idx    = gnt_idx;
      nxt_valid  = 1'b0;
      nxt_ptr    = ptr;
      nxt_hold   = hold_cnt;
      nxt_forced = 1'b0;
      case (state)
         ST_GRANT: begin
            if (!req[gnt_idx]) begin
               nxt_state = ST_TURN;
            end else if (hold_cnt == HOLD_MAX && others != 8'h00) begin
               nxt_state  = ST_TURN;
               nxt_forced = 1'b1;
            end else begin
               nxt_valid = 1'b1;
               if (hold_cnt != HOLD_MAX) nxt_hold = hold_cnt + 1'b1;
            end
         end
         // IDLE and the single TURN cycle both hand out a fresh grant when possible.
         ST_IDLE, ST_TURN: begin
            if (en && req != 8'h00) begin
               nxt_state = ST_GRANT;
               nxt_idx   = win;
               nxt_valid = 1'b1;
               nxt_ptr   = win + 3'd1;
               nxt_hold  = HCW'(1);
            end else begin
               nxt_state = ST_IDLE;
            end
         end
         default: nxt_state = ST_IDLE;
      endcase
   end

   cs_decode3_8 u_decode (
      .en   (nxt_valid),
      .idx  (nxt_idx),
      .cs_n (nxt_cs_n)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         ptr       <= 3'd0;
         hold_cnt  <= '0;
         gnt_valid <= 1'b0;
         gnt_idx   <= 3'd0;
         cs_n      <= CS_IDLE;
         forced    <= 1'b0;
      end else begin
         state     <= nxt_state;
         ptr       <= nxt_ptr;
         hold_cnt  <= nxt_hold;
         gnt_valid <= nxt_valid;
         gnt_idx   <= nxt_idx;
         cs_n      <= nxt_cs_n;
         forced    <= nxt_forced;
      end
   end

endmodule

// File: tb/tb_rr_cs_arbiter8.sv
// Directed bench for rr_cs_arbiter8: one instance at MAX_HOLD=16, one at MAX_HOLD=4.
module tb_rr_cs_arbiter8;

   logic       clk = 1'b0;
   logic       rst;
   logic       en16, en4;
   logic [7:0] req16, req4;
   logic       gv16, gv4, f16, f4;
   logic [2:0] idx16, idx4;
   logic [7:0] cs16, cs4;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rr_cs_arbiter8 #(.MAX_HOLD(16)) dut16 (
      .clk(clk), .rst(rst), .en(en16), .req(req16),
      .gnt_valid(gv16), .gnt_idx(idx16), .cs_n(cs16), .forced(f16)
   );

   rr_cs_arbiter8 #(.MAX_HOLD(4)) dut4 (
      .clk(clk), .rst(rst), .en(en4), .req(req4),
      .gnt_valid(gv4), .gnt_idx(idx4), .cs_n(cs4), .forced(f4)
   );

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int ok;
      logic [2:0] e_idx;
      logic [7:0] e_cs;

      rst = 1'b1; en16 = 1'b0; en4 = 1'b0; req16 = 8'h00; req4 = 8'h00;
      step(); step();
      check_vec("rst_gv16",  gv16,  0);
      check_vec("rst_idx16", idx16, 0);
      check_vec("rst_cs16",  cs16,  8'hFF);
      check_vec("rst_f16",   f16,   0);
      check_vec("rst_cs4",   cs4,   8'hFF);
      rst = 1'b0;

      // Single requester
      en16 = 1'b1; req16 = 8'h08;
      step();
      check_vec("single_gv",  gv16,  1);
      check_vec("single_idx", idx16, 3);
      check_vec("single_cs",  cs16,  8'hF7);
      req16 = 8'h00;
      step();
      check_vec("single_rel_gv",  gv16,  0);
      check_vec("single_rel_cs",  cs16,  8'hFF);
      check_vec("single_rel_idx", idx16, 3);
      step();
      check_vec("single_idle_gv", gv16, 0);

      // No contention: pointer is 4, so 0x20 wins index 5 and keeps it
      req16 = 8'h20;
      ok = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (gv16 === 1'b1 && idx16 === 3'd5 && cs16 === 8'hDF && f16 === 1'b0) ok++;
      end
      check_vec("nocont_cycles", ok, 40);
      req16 = 8'h00;
      step();
      check_vec("nocont_rel_gv", gv16, 0);
      step();

      // Wrap-around: pointer 6, grant 7, then 0x41 must pick 0
      req16 = 8'h80;
      step();
      check_vec("wrap_g7_idx", idx16, 7);
      check_vec("wrap_g7_cs",  cs16,  8'h7F);
      req16 = 8'h41;
      step();
      check_vec("wrap_turn_gv", gv16, 0);
      check_vec("wrap_turn_f",  f16,  0);
      step();
      check_vec("wrap_next_idx", idx16, 0);
      check_vec("wrap_next_cs",  cs16,  8'hFE);
      req16 = 8'h00;
      step(); step();

      // Enable gating: pointer is 1
      en16 = 1'b0; req16 = 8'hFF;
      ok = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (gv16 === 1'b0 && cs16 === 8'hFF) ok++;
      end
      check_vec("en_block", ok, 3);
      en16 = 1'b1;
      step();
      check_vec("en_grant_idx", idx16, 1);
      check_vec("en_grant_cs",  cs16,  8'hFD);
      en16 = 1'b0;
      ok = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (gv16 === 1'b1 && idx16 === 3'd1) ok++;
      end
      check_vec("en_hold", ok, 3);
      req16 = 8'h00;
      step();
      check_vec("en_rel_gv", gv16, 0);
      req16 = 8'hFF;
      step();
      check_vec("en_idle_gv1", gv16, 0);
      step();
      check_vec("en_idle_gv2", gv16, 0);

      // Reset mid-grant: pointer 2, 0x04 wins index 2
      en16 = 1'b1; req16 = 8'h04;
      step();
      check_vec("rstmid_pre_idx", idx16, 2);
      check_vec("rstmid_pre_gv",  gv16,  1);
      #2 rst = 1'b1;
      #1;
      check_vec("rstmid_gv",  gv16,  0);
      check_vec("rstmid_cs",  cs16,  8'hFF);
      check_vec("rstmid_idx", idx16, 0);
      rst = 1'b0;
      req16 = 8'h05;
      step();
      check_vec("rstmid_first_idx", idx16, 0);
      check_vec("rstmid_first_cs",  cs16,  8'hFE);
      req16 = 8'h04;
      step();
      check_vec("rstmid_turn_gv", gv16, 0);
      step();
      check_vec("rstmid_second_idx", idx16, 2);
      check_vec("rstmid_second_cs",  cs16,  8'hFB);
      req16 = 8'h00;

      // Round robin with hold limit 4: 0,7,0,7 with forced turnarounds
      en4 = 1'b1; req4 = 8'h81;
      step();
      for (int g = 0; g < 4; g++) begin
         e_idx = (g % 2 == 0) ? 3'd0 : 3'd7;
         e_cs  = (g % 2 == 0) ? 8'hFE : 8'h7F;
         ok = 0;
         for (int c = 0; c < 4; c++) begin
            if (gv4 === 1'b1 && idx4 === e_idx && cs4 === e_cs && f4 === 1'b0) ok++;
            step();
         end
         check_vec("rr_tenure", ok, 4);
         check_vec("rr_turn_gv", gv4, 0);
         check_vec("rr_turn_cs", cs4, 8'hFF);
         check_vec("rr_forced",  f4,  1);
         step();
      end
      check_vec("rr_fifth_idx", idx4, 0);
      check_vec("rr_fifth_f",   f4,   0);
      req4 = 8'h00;
      step();
      check_vec("rr_norm_rel_gv", gv4, 0);
      check_vec("rr_norm_rel_f",  f4,  0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
